// File: rtl/sort_frame_ctrl_pkg.sv
// Shared types and constants for the sorter frame scheduler.
package sort_frame_ctrl_pkg;

    localparam int unsigned DEF_DATA_W = 32;

    // Sorter depth is fixed in hardware.
    localparam int unsigned DEF_FRAME_LEN = 32;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_PAD     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sort_frame_ctrl_len_fifo.sv
// Frame-length FIFO: one entry per frame issued to the sorter and not yet drained.
module sort_frame_ctrl_len_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sort_frame_ctrl.sv
// Pads upstream frames to the sorter depth and strips the padding from the sorted stream.
// Optional statistics counters are built when SORT_STATS_EN is defined.
module sort_frame_ctrl
    import sort_frame_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned FRAME_LEN    = DEF_FRAME_LEN,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_W-1:0]               s_data,
    input  logic                            s_valid,
    input  logic                            s_last,
    output logic                            s_ready,
    output logic [DATA_W-1:0]               sort_in,
    output logic                            sort_valid,
    output logic                            sort_last,
    input  logic                            sort_ready,
    input  logic [DATA_W-1:0]               sort_out,
    input  logic                            sort_vout,
    input  logic                            sort_lout,
    output logic [DATA_W-1:0]               m_data,
    output logic                            m_valid,
    output logic                            m_last,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight,
    output logic                            err_len,
    output logic                            err_sync,
    output logic [15:0]                     stat_frames,
    output logic [15:0]                     stat_pads
);
    localparam int unsigned LEN_W    = $clog2(FRAME_LEN) + 1;
    localparam int unsigned CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [DATA_W-1:0] PAD_WORD = {DATA_W{1'b1}};

    state_t             r_state;
    logic [CNT_W-1:0]   r_in_cnt;
    logic [LEN_W-1:0]   r_len;
    logic [DATA_W-1:0]  r_sort_in;
    logic               r_sort_valid;
    logic               r_sort_last;
    logic               r_err_len;
    logic [CNT_W-1:0]   r_out_cnt;
    logic [DATA_W-1:0]  r_m_data;
    logic               r_m_valid;
    logic               r_m_last;
    logic               r_err_sync;

    logic               w_full;
    logic               w_empty;
    logic [LEN_W-1:0]   w_head_len;
    logic               w_accept;
    logic               w_pad_go;
    logic               w_in_last;
    logic               w_push;
    logic [LEN_W-1:0]   w_push_len;
    logic               w_vout_ok;
    logic               w_out_last;
    logic               w_pop;
    logic               w_m_last_nxt;

    always_comb begin
        s_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_LOAD:    s_ready = sort_ready && !w_full;
                ST_DISCARD: s_ready = 1'b1;
                default:    s_ready = 1'b0;
            endcase
        end
    end

    assign w_accept   = s_valid && s_ready;
    assign w_pad_go   = (r_state == ST_PAD) && sort_ready && !w_full;
    assign w_in_last  = (r_in_cnt == LAST_IDX);
    assign w_push     = ((r_state == ST_LOAD) && w_accept && w_in_last) || (w_pad_go && w_in_last);
    assign w_push_len = (r_state == ST_PAD) ? r_len : LEN_W'(FRAME_LEN);

    // Input FSM: forward, pad, or discard upstream words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_LOAD;
            r_in_cnt     <= '0;
            r_len        <= '0;
            r_sort_in    <= '0;
            r_sort_valid <= 1'b0;
            r_sort_last  <= 1'b0;
            r_err_len    <= 1'b0;
        end else begin
            r_sort_valid <= 1'b0;
            r_sort_last  <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_sort_in    <= s_data;
                        r_sort_valid <= 1'b1;
                        if (w_in_last) begin
                            r_sort_last <= 1'b1;
                            r_in_cnt    <= '0;
                            if (!s_last) begin
                                r_err_len <= 1'b1;
                                r_state   <= ST_DISCARD;
                            end
                        end else begin
                            r_in_cnt <= r_in_cnt + CNT_W'(1);
                            if (s_last) begin
                                r_len   <= LEN_W'(r_in_cnt) + LEN_W'(1);
                                r_state <= ST_PAD;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if (w_pad_go) begin
                        r_sort_in    <= PAD_WORD;
                        r_sort_valid <= 1'b1;
                        if (w_in_last) begin
                            r_sort_last <= 1'b1;
                            r_in_cnt    <= '0;
                            r_state     <= ST_LOAD;
                        end else begin
                            r_in_cnt <= r_in_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DISCARD: begin
                    if (w_accept && s_last) begin
                        r_state <= ST_LOAD;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign w_vout_ok    = sort_vout && !w_empty;
    assign w_out_last   = (r_out_cnt == LAST_IDX);
    assign w_pop        = w_vout_ok && w_out_last;
    assign w_m_last_nxt = w_vout_ok && ((LEN_W'(r_out_cnt) + LEN_W'(1)) == w_head_len);

    // Output side: keep the first head_len words of every sorted frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_cnt  <= '0;
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_err_sync <= 1'b0;
        end else begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            if (sort_vout && w_empty) begin
                r_err_sync <= 1'b1;
            end
            if (w_vout_ok) begin
                r_m_data  <= sort_out;
                r_m_valid <= (LEN_W'(r_out_cnt) < w_head_len);
                r_m_last  <= w_m_last_nxt;
                if (sort_lout != w_out_last) begin
                    r_err_sync <= 1'b1;
                end
                r_out_cnt <= w_out_last ? '0 : r_out_cnt + CNT_W'(1);
            end
        end
    end

    sort_frame_ctrl_len_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (LEN_W)
    ) u_len_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_push_len),
        .i_pop   (w_pop),
        .o_rdata (w_head_len),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (inflight)
    );

`ifdef SORT_STATS_EN
    logic [15:0] r_stat_frames;
    logic [15:0] r_stat_pads;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_frames <= '0;
            r_stat_pads   <= '0;
        end else begin
            if (w_m_last_nxt) begin
                r_stat_frames <= sat_inc16(r_stat_frames);
            end
            if (w_pad_go) begin
                r_stat_pads <= sat_inc16(r_stat_pads);
            end
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_pads   = r_stat_pads;
`else
    assign stat_frames = '0;
    assign stat_pads   = '0;
`endif

    assign sort_in    = r_sort_in;
    assign sort_valid = r_sort_valid;
    assign sort_last  = r_sort_last;
    assign m_data     = r_m_data;
    assign m_valid    = r_m_valid;
    assign m_last     = r_m_last;
    assign err_len    = r_err_len;
    assign err_sync   = r_err_sync;

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Bench for sort_frame_ctrl with a behavioural 32-deep sorter model on the sorter ports.
module tb_sort_frame_ctrl;
    localparam int DW = 16;
    localparam int FL = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid, s_last, s_ready;
    logic [DW-1:0] sort_in;
    logic          sort_valid, sort_last, sort_ready;
    logic [DW-1:0] sort_out;
    logic          sort_vout, sort_lout;
    logic [DW-1:0] m_data;
    logic          m_valid, m_last;
    logic [2:0]    inflight;
    logic          err_len, err_sync;
    logic [15:0]   stat_frames, stat_pads;

    sort_frame_ctrl #(.DATA_W(DW), .FRAME_LEN(FL), .MAX_INFLIGHT(4)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .sort_in(sort_in), .sort_valid(sort_valid), .sort_last(sort_last), .sort_ready(sort_ready),
        .sort_out(sort_out), .sort_vout(sort_vout), .sort_lout(sort_lout),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .inflight(inflight), .err_len(err_len), .err_sync(err_sync),
        .stat_frames(stat_frames), .stat_pads(stat_pads)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sorter model: collects a frame, sorts it, replays it with last_out on word 31.
    logic [DW-1:0] cap[$];
    logic [DW-1:0] outq[$];
    int  ocnt = 0;
    int  cap_bad = 0;
    bit  out_en = 1'b1;
    int  inject_req = 0;
    int  inject_seen = 0;

    initial begin
        sort_out = '0; sort_vout = 1'b0; sort_lout = 1'b0;
        forever begin
            @(posedge clk); #1;
            sort_vout = 1'b0; sort_lout = 1'b0;
            if (rst) begin
                outq.delete(); ocnt = 0;
            end else if (inject_req != inject_seen) begin
                inject_seen = inject_req;
                sort_out = 16'h0055; sort_vout = 1'b1;
            end else if (out_en && outq.size() > 0) begin
                sort_out = outq.pop_front(); sort_vout = 1'b1;
                sort_lout = (ocnt == FL-1);
                ocnt = (ocnt + 1) % FL;
            end
            @(negedge clk);
            if (rst) begin
                cap.delete();
            end else if (sort_valid) begin
                cap.push_back(sort_in);
                if (sort_last) begin
                    if (cap.size() != FL) cap_bad++;
                    cap.sort();
                    foreach (cap[k]) outq.push_back(cap[k]);
                    cap.delete();
                end
            end
        end
    end

    logic [DW-1:0] rx_d[$];
    bit            rx_l[$];
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            rx_d.push_back(m_data);
            rx_l.push_back(m_last);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    logic [DW-1:0] txw[$];
    logic [DW-1:0] expq[$];

    task automatic send_frame(input int n, output bit ok);
        int i = 0;
        int guard = 0;
        bit acc;
        ok = 1'b1;
        while (i < n) begin
            s_valid = 1'b1; s_data = txw[i]; s_last = (i == n-1);
            @(negedge clk); acc = s_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
            if (guard > 4000) begin ok = 1'b0; break; end
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int g = 0;
        repeat (36) @(posedge clk); #1;
        while (inflight != 0 && g < 3000) begin @(posedge clk); #1; g++; end
        repeat (3) @(posedge clk); #1;
        check({name, "_drain"}, 32'(g < 3000), 32'd1);
    endtask

    task automatic check_rx(input string name, input int base, input int n);
        int bad = 0;
        int lasts = 0;
        check({name, "_cnt"}, 32'(rx_d.size() - base), 32'(n));
        if (rx_d.size() - base == n) begin
            for (int k = 0; k < n; k++) begin
                if (rx_d[base+k] !== expq[k]) bad++;
                if (rx_l[base+k]) lasts++;
            end
            check({name, "_data_bad"}, 32'(bad), 32'd0);
            check({name, "_mlast_pos"}, 32'(rx_l[base+n-1]), 32'd1);
            check({name, "_mlast_cnt"}, 32'(lasts), 32'd1);
        end
    endtask

    typedef struct {
        int          len;
        logic [15:0] base;
        logic [15:0] step;
        bit          do_rst;
        int          exp_cnt;
        int          exp_pads;
        bit          exp_err_len;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int  rb;
        int  n;
        int  pads_acc;
        int  frames_acc;
        bit  ok;

        tbl[0] = '{32, 16'h1000, 16'hFF9D, 1'b1, 32, 0,  1'b0};
        tbl[1] = '{17, 16'h0123, 16'h2345, 1'b1, 17, 15, 1'b0};
        tbl[2] = '{1,  16'h00AA, 16'h0000, 1'b1, 1,  31, 1'b0};
        tbl[3] = '{3,  16'hFFFF, 16'h0000, 1'b1, 3,  29, 1'b0};
        tbl[4] = '{40, 16'h0500, 16'h0007, 1'b1, 32, 0,  1'b1};
        tbl[5] = '{7,  16'h0900, 16'hFFF0, 1'b0, 7,  25, 1'b1};
        tbl[6] = '{31, 16'h4000, 16'h0101, 1'b1, 31, 1,  1'b0};

        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; sort_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sort_valid", 32'(sort_valid), 32'd0);
        check("rst_sort_last",  32'(sort_last),  32'd0);
        check("rst_sort_in",    32'(sort_in),    32'd0);
        check("rst_s_ready",    32'(s_ready),    32'd0);
        check("rst_m_valid",    32'(m_valid),    32'd0);
        check("rst_m_last",     32'(m_last),     32'd0);
        check("rst_m_data",     32'(m_data),     32'd0);
        check("rst_inflight",   32'(inflight),   32'd0);
        check("rst_err_len",    32'(err_len),    32'd0);
        check("rst_err_sync",   32'(err_sync),   32'd0);
        check("rst_stat_frames", 32'(stat_frames), 32'd0);
        check("rst_stat_pads",  32'(stat_pads),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;

        pads_acc = 0; frames_acc = 0;
        foreach (tbl[i]) begin
            if (tbl[i].do_rst) begin
                do_reset();
                pads_acc = 0; frames_acc = 0;
            end
            txw.delete(); expq.delete();
            for (int k = 0; k < tbl[i].len; k++) txw.push_back(16'(tbl[i].base + 16'(k) * tbl[i].step));
            n = (tbl[i].len < FL) ? tbl[i].len : FL;
            for (int k = 0; k < n; k++) expq.push_back(txw[k]);
            expq.sort();
            rb = rx_d.size();
            send_frame(tbl[i].len, ok);
            check($sformatf("v%0d_send", i), 32'(ok), 32'd1);
            drain($sformatf("v%0d", i));
            check_rx($sformatf("v%0d", i), rb, tbl[i].exp_cnt);
            pads_acc += tbl[i].exp_pads; frames_acc++;
            check($sformatf("v%0d_err_len", i), 32'(err_len), 32'(tbl[i].exp_err_len));
            check($sformatf("v%0d_err_sync", i), 32'(err_sync), 32'd0);
`ifdef SORT_STATS_EN
            check($sformatf("v%0d_stat_pads", i), 32'(stat_pads), 32'(pads_acc));
            check($sformatf("v%0d_stat_frames", i), 32'(stat_frames), 32'(frames_acc));
`else
            check($sformatf("v%0d_stat_pads", i), 32'(stat_pads), 32'd0);
            check($sformatf("v%0d_stat_frames", i), 32'(stat_frames), 32'd0);
`endif
        end

        // Five-word frame from the worked example.
        do_reset();
        txw = '{16'd9, 16'd3, 16'd7, 16'd1, 16'd5};
        expq = '{16'd1, 16'd3, 16'd5, 16'd7, 16'd9};
        rb = rx_d.size();
        send_frame(5, ok);
        drain("f5");
        check_rx("f5", rb, 5);
`ifdef SORT_STATS_EN
        check("f5_stat_pads", 32'(stat_pads), 32'd27);
`else
        check("f5_stat_pads", 32'(stat_pads), 32'd0);
`endif

        // Four frames fill the length FIFO while the sorter holds its output.
        do_reset();
        out_en = 1'b0;
        rb = rx_d.size();
        for (int f = 0; f < 4; f++) begin
            txw = '{16'(f + 1)};
            send_frame(1, ok);
            check($sformatf("full_send%0d", f), 32'(ok), 32'd1);
        end
        repeat (40) @(posedge clk); #1;
        check("full_inflight", 32'(inflight), 32'd4);
        @(negedge clk);
        check("full_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        out_en = 1'b1;
        txw = '{16'd5};
        send_frame(1, ok);
        check("full_send4", 32'(ok), 32'd1);
        drain("full");
        expq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        check("full_cnt", 32'(rx_d.size() - rb), 32'd5);
        if (rx_d.size() - rb == 5) begin
            for (int k = 0; k < 5; k++) begin
                check($sformatf("full_d%0d", k), 32'(rx_d[rb+k]), 32'(expq[k]));
                check($sformatf("full_l%0d", k), 32'(rx_l[rb+k]), 32'd1);
            end
        end

        // Sorter backpressure mid-frame and again during padding.
        do_reset();
        cap_bad = 0;
        txw.delete();
        for (int k = 0; k < 10; k++) txw.push_back(16'(16'h0300 - 16'(k * 13)));
        expq = txw; expq.sort();
        rb = rx_d.size();
        fork
            send_frame(10, ok);
            begin
                repeat (4) @(posedge clk);
                #2 sort_ready = 1'b0;
                @(negedge clk); @(negedge clk);
                check("bp1_sort_valid", 32'(sort_valid), 32'd0);
                @(posedge clk); @(posedge clk);
                #2 sort_ready = 1'b1;
                repeat (10) @(posedge clk);
                #2 sort_ready = 1'b0;
                @(negedge clk); @(negedge clk);
                check("bp2_sort_valid", 32'(sort_valid), 32'd0);
                @(posedge clk); @(posedge clk);
                #2 sort_ready = 1'b1;
            end
        join
        @(posedge clk); #1;
        check("bp_send", 32'(ok), 32'd1);
        drain("bp");
        check_rx("bp", rb, 10);
        check("bp_frame_words", 32'(cap_bad), 32'd0);

        // Reset while padding, then a fresh full frame.
        do_reset();
        txw = '{16'h0AAA, 16'h0BBB};
        send_frame(2, ok);
        repeat (5) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_sort_valid", 32'(sort_valid), 32'd0);
        check("mid_rst_sort_in",    32'(sort_in),    32'd0);
        check("mid_rst_s_ready",    32'(s_ready),    32'd0);
        check("mid_rst_inflight",   32'(inflight),   32'd0);
        check("mid_rst_m_valid",    32'(m_valid),    32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        txw.delete();
        for (int k = 0; k < 32; k++) txw.push_back(16'((k * 7919) % 65521));
        expq = txw; expq.sort();
        rb = rx_d.size();
        send_frame(32, ok);
        drain("post_rst");
        check_rx("post_rst", rb, 32);
        check("post_rst_err_sync", 32'(err_sync), 32'd0);

        // Sorter output with nothing in flight.
        rb = rx_d.size();
        inject_req++;
        repeat (4) @(posedge clk); #1;
        check("orphan_err_sync", 32'(err_sync), 32'd1);
        check("orphan_dropped", 32'(rx_d.size() - rb), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
